// File: rtl/voxel_gpu_cmd_master.sv
// Avalon-MM initiator for the voxel GPU register slave, fed by a small command FIFO.
// Optional watchdog on waitrequest/irq stalls is built when VOXEL_MASTER_TIMEOUT_EN is defined.
module voxel_gpu_cmd_master #(
    parameter int ADDR_W         = 8,
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_address,
    input  logic [31:0]       cmd_writedata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_readdata,
    output logic [ADDR_W-1:0] m_address,
    output logic              m_read,
    output logic              m_write,
    output logic [31:0]       m_writedata,
    input  logic [31:0]       m_readdata,
    input  logic              m_waitrequest,
    input  logic              irq,
    output logic              busy,
    output logic              error
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = AW + 1;

    localparam logic [1:0] OP_WR  = 2'b00;
    localparam logic [1:0] OP_RD  = 2'b01;
    localparam logic [1:0] OP_IRQ = 2'b10;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        BUS      = 2'd1,
        RSP      = 2'd2,
        WAIT_IRQ = 2'd3
    } state_t;

    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("voxel_gpu_cmd_master: illegal parameter values");
    end

    // Command FIFO: extra pointer bit distinguishes full from empty.
    logic [1:0]        fifo_op   [FIFO_DEPTH];
    logic [ADDR_W-1:0] fifo_addr [FIFO_DEPTH];
    logic [31:0]       fifo_data [FIFO_DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic              full;
    logic              empty;
    logic              push;
    logic              pop;
    logic [1:0]        head_op;
    logic [ADDR_W-1:0] head_addr;
    logic [31:0]       head_data;

    assign empty     = (wr_ptr == rd_ptr);
    assign full      = (wr_ptr[PW-1] != rd_ptr[PW-1]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign cmd_ready = !full;
    assign push      = cmd_valid && !full;
    assign head_op   = fifo_op[rd_ptr[AW-1:0]];
    assign head_addr = fifo_addr[rd_ptr[AW-1:0]];
    assign head_data = fifo_data[rd_ptr[AW-1:0]];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (push) begin
            fifo_op[wr_ptr[AW-1:0]]   <= cmd_op;
            fifo_addr[wr_ptr[AW-1:0]] <= cmd_address;
            fifo_data[wr_ptr[AW-1:0]] <= cmd_writedata;
        end
    end

    state_t     state;
    state_t     state_nxt;
    logic [1:0] cur_op;
    logic       tmo_hit;

`ifdef VOXEL_MASTER_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] tmo_cnt;
    logic          stalled;
    logic          err_q;

    assign stalled = (state == BUS && m_waitrequest) || (state == WAIT_IRQ && !irq);
    assign tmo_hit = stalled && (tmo_cnt == CW'(TIMEOUT_CYCLES - 1));
    assign error   = err_q;

    // BUS/WAIT_IRQ are only entered from IDLE, so clearing outside them covers entry.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            tmo_cnt <= '0;
            err_q   <= 1'b0;
        end else begin
            if (state == IDLE || state == RSP) tmo_cnt <= '0;
            else if (stalled)                  tmo_cnt <= tmo_cnt + 1'b1;
            if (tmo_hit) err_q <= 1'b1;
        end
    end
`else
    assign tmo_hit = 1'b0;
    assign error   = 1'b0;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        case (state)
            IDLE: begin
                if (!empty) begin
                    pop = 1'b1;
                    case (head_op)
                        OP_WR, OP_RD: state_nxt = BUS;
                        OP_IRQ:       state_nxt = WAIT_IRQ;
                        default:      state_nxt = IDLE;
                    endcase
                end
            end
            BUS: begin
                if (!m_waitrequest || tmo_hit)
                    state_nxt = (cur_op == OP_RD) ? RSP : IDLE;
            end
            RSP: begin
                if (rsp_ready) state_nxt = IDLE;
            end
            WAIT_IRQ: begin
                if (irq || tmo_hit) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cur_op       <= OP_WR;
            m_address    <= '0;
            m_writedata  <= '0;
            rsp_readdata <= '0;
        end else begin
            if (pop) begin
                cur_op <= head_op;
                if (head_op == OP_WR || head_op == OP_RD) begin
                    m_address   <= head_addr;
                    m_writedata <= head_data;
                end
            end
            // A timed-out read still returns a response, marked by all-ones data.
            if (state == BUS && cur_op == OP_RD) begin
                if (!m_waitrequest) rsp_readdata <= m_readdata;
                else if (tmo_hit)   rsp_readdata <= 32'hFFFF_FFFF;
            end
        end
    end

    assign m_write   = (state == BUS) && (cur_op == OP_WR);
    assign m_read    = (state == BUS) && (cur_op == OP_RD);
    assign rsp_valid = (state == RSP);
    assign busy      = !empty || (state != IDLE);

endmodule

// File: tb/tb_voxel_gpu_cmd_master.sv
// Directed bench for voxel_gpu_cmd_master: vector table plus hand-written stall/irq/reset sequences.
module tb_voxel_gpu_cmd_master;

    logic        clock;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [7:0]  cmd_address;
    logic [31:0] cmd_writedata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_readdata;
    logic [7:0]  m_address;
    logic        m_read;
    logic        m_write;
    logic [31:0] m_writedata;
    logic [31:0] m_readdata;
    logic        m_waitrequest;
    logic        irq;
    logic        busy;
    logic        error;

    int total = 0;
    int bad   = 0;

    voxel_gpu_cmd_master #(
        .ADDR_W(8),
        .FIFO_DEPTH(4),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .clock(clock),
        .reset(reset),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_op(cmd_op),
        .cmd_address(cmd_address),
        .cmd_writedata(cmd_writedata),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_readdata(rsp_readdata),
        .m_address(m_address),
        .m_read(m_read),
        .m_write(m_write),
        .m_writedata(m_writedata),
        .m_readdata(m_readdata),
        .m_waitrequest(m_waitrequest),
        .irq(irq),
        .busy(busy),
        .error(error)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, act=running exp=finished");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: act=%h exp=%h", name, act, exp);
        end
    endtask

    // Advance one cycle; sample point is 1 time unit after the rising edge.
    task automatic step();
        @(posedge clock);
        #1;
        chk("strobe_exclusive", 32'(m_read && m_write), 32'(0));
    endtask

    task automatic offer(input logic [1:0] op, input logic [7:0] addr, input logic [31:0] data);
        cmd_valid     = 1'b1;
        cmd_op        = op;
        cmd_address   = addr;
        cmd_writedata = data;
    endtask

    typedef struct {
        logic [1:0]  op;
        logic [7:0]  addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        exp_wr;
        logic        exp_rd;
    } vec_t;

    vec_t       vt[5];
    logic [7:0] seen[$];
    int         k;

`ifdef VOXEL_MASTER_TIMEOUT_EN
    localparam int IRQ_WAIT = 5;
`else
    localparam int IRQ_WAIT = 10;
`endif

    initial begin
        vt[0] = '{op: 2'b00, addr: 8'h00, wdata: 32'h1234_5678, rdata: 32'h0,         exp_wr: 1'b1, exp_rd: 1'b0};
        vt[1] = '{op: 2'b01, addr: 8'h01, wdata: 32'h0,         rdata: 32'hCAFE_F00D, exp_wr: 1'b0, exp_rd: 1'b1};
        vt[2] = '{op: 2'b00, addr: 8'hA5, wdata: 32'hDEAD_BEEF, rdata: 32'h0,         exp_wr: 1'b1, exp_rd: 1'b0};
        vt[3] = '{op: 2'b11, addr: 8'h33, wdata: 32'h5555_AAAA, rdata: 32'h0,         exp_wr: 1'b0, exp_rd: 1'b0};
        vt[4] = '{op: 2'b01, addr: 8'hFF, wdata: 32'h0,         rdata: 32'h0000_0001, exp_wr: 1'b0, exp_rd: 1'b1};

        reset = 1'b1; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_address = 8'h00; cmd_writedata = 32'h0;
        rsp_ready = 1'b0; m_readdata = 32'h0; m_waitrequest = 1'b0; irq = 1'b0;
        #12;
        chk("rst_m_write", 32'(m_write), 32'(0));
        chk("rst_m_read", 32'(m_read), 32'(0));
        chk("rst_m_address", 32'(m_address), 32'(0));
        chk("rst_m_writedata", m_writedata, 32'h0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'(0));
        chk("rst_rsp_readdata", rsp_readdata, 32'h0);
        chk("rst_error", 32'(error), 32'(0));
        chk("rst_cmd_ready", 32'(cmd_ready), 32'(1));
        chk("rst_busy", 32'(busy), 32'(0));
        #11;
        reset = 1'b0;
        step();

        // Single commands with a ready slave.
        for (int i = 0; i < 5; i++) begin
            m_readdata = vt[i].rdata;
            offer(vt[i].op, vt[i].addr, vt[i].wdata);
            step();
            cmd_valid = 1'b0;
            chk("vec_busy_after_push", 32'(busy), 32'(1));
            chk("vec_no_strobe_early", 32'(m_write || m_read), 32'(0));
            step();
            chk("vec_m_write", 32'(m_write), 32'(vt[i].exp_wr));
            chk("vec_m_read", 32'(m_read), 32'(vt[i].exp_rd));
            if (vt[i].exp_wr || vt[i].exp_rd) chk("vec_m_address", 32'(m_address), 32'(vt[i].addr));
            if (vt[i].exp_wr) chk("vec_m_writedata", m_writedata, vt[i].wdata);
            step();
            chk("vec_strobe_off", 32'(m_write || m_read), 32'(0));
            chk("vec_rsp_valid", 32'(rsp_valid), 32'(vt[i].exp_rd));
            chk("vec_busy", 32'(busy), 32'(vt[i].exp_rd));
            if (vt[i].exp_rd) begin
                chk("vec_rsp_readdata", rsp_readdata, vt[i].rdata);
                rsp_ready = 1'b1;
                step();
                rsp_ready = 1'b0;
                chk("vec_rsp_cleared", 32'(rsp_valid), 32'(0));
                chk("vec_busy_done", 32'(busy), 32'(0));
            end
        end

        // Response held under backpressure; a queued write must wait for RSP to finish.
        m_readdata = 32'hCAFE_F00D;
        offer(2'b01, 8'h01, 32'h0);
        step();
        cmd_valid = 1'b0;
        step();
        chk("hold_m_read", 32'(m_read), 32'(1));
        step();
        m_readdata = 32'h0;
        offer(2'b00, 8'h10, 32'h0000_0055);
        for (int i = 0; i < 5; i++) begin
            chk("hold_rsp_valid", 32'(rsp_valid), 32'(1));
            chk("hold_rsp_readdata", rsp_readdata, 32'hCAFE_F00D);
            chk("hold_no_pop", 32'(m_write), 32'(0));
            step();
            cmd_valid = 1'b0;
        end
        rsp_ready = 1'b1;
        chk("hold_last_valid", 32'(rsp_valid), 32'(1));
        step();
        rsp_ready = 1'b0;
        chk("hold_rsp_cleared", 32'(rsp_valid), 32'(0));
        chk("hold_wr_not_yet", 32'(m_write), 32'(0));
        step();
        chk("hold_queued_write", 32'(m_write), 32'(1));
        chk("hold_queued_addr", 32'(m_address), 32'h10);
        step();
        chk("hold_idle", 32'(busy), 32'(0));

        // Write stalled by waitrequest for 3 cycles.
        m_waitrequest = 1'b1;
        offer(2'b00, 8'h22, 32'h0BAD_F00D);
        step();
        cmd_valid = 1'b0;
        step();
        for (int i = 0; i < 4; i++) begin
            chk("stall_m_write", 32'(m_write), 32'(1));
            chk("stall_m_address", 32'(m_address), 32'h22);
            chk("stall_m_writedata", m_writedata, 32'h0BAD_F00D);
            if (i == 3) m_waitrequest = 1'b0;
            step();
        end
        chk("stall_m_write_off", 32'(m_write), 32'(0));

        // Fill the FIFO behind a stalled write, then drain and check order.
        m_waitrequest = 1'b1;
        k = 0;
        seen.delete();
        for (int c = 0; c < 8; c++) begin
            logic [7:0] exp_rdy;
            exp_rdy = 8'b1001_1111;
            cmd_valid = (k < 6);
            cmd_op = 2'b00;
            cmd_address = 8'h40 + 8'(k);
            cmd_writedata = 32'h100 + 32'(k);
            if (c == 5) m_waitrequest = 1'b0;
            chk("full_cmd_ready", 32'(cmd_ready), 32'(exp_rdy[c]));
            if (cmd_ready && cmd_valid) k++;
            if (m_write && !m_waitrequest) seen.push_back(m_address);
            step();
        end
        cmd_valid = 1'b0;
        for (int c = 0; c < 30 && seen.size() < 6; c++) begin
            if (m_write && !m_waitrequest) seen.push_back(m_address);
            step();
        end
        chk("full_issued_count", 32'(seen.size()), 32'(6));
        for (int i = 0; i < 6 && i < seen.size(); i++)
            chk("full_order", 32'(seen[i]), 32'h40 + 32'(i));
        chk("full_drained", 32'(busy), 32'(0));

        // Wait-for-interrupt gating a following write.
        offer(2'b10, 8'h00, 32'h0);
        step();
        offer(2'b00, 8'h00, 32'h0000_0077);
        step();
        cmd_valid = 1'b0;
        for (int i = 0; i < IRQ_WAIT; i++) begin
            chk("irq_blocked", 32'(m_write), 32'(0));
            step();
        end
        chk("irq_busy", 32'(busy), 32'(1));
        irq = 1'b1;
        step();
        irq = 1'b0;
        chk("irq_plus1", 32'(m_write), 32'(0));
        step();
        chk("irq_plus2_write", 32'(m_write), 32'(1));
        chk("irq_plus2_data", m_writedata, 32'h0000_0077);
        step();
        chk("irq_done", 32'(busy), 32'(0));
        chk("irq_no_error", 32'(error), 32'(0));

        // Read against a slave stuck in waitrequest.
        m_waitrequest = 1'b1;
        m_readdata = 32'h1111_2222;
        offer(2'b01, 8'h07, 32'h0);
        step();
        cmd_valid = 1'b0;
        step();
`ifdef VOXEL_MASTER_TIMEOUT_EN
        for (int i = 0; i < 8; i++) begin
            chk("tmo_m_read_high", 32'(m_read), 32'(1));
            step();
        end
        chk("tmo_m_read_dropped", 32'(m_read), 32'(0));
        chk("tmo_error", 32'(error), 32'(1));
        chk("tmo_rsp_valid", 32'(rsp_valid), 32'(1));
        chk("tmo_rsp_readdata", rsp_readdata, 32'hFFFF_FFFF);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        chk("tmo_error_sticky", 32'(error), 32'(1));
        offer(2'b01, 8'h08, 32'h0);
        step();
        cmd_valid = 1'b0;
        step();
`else
        for (int i = 0; i < 12; i++) step();
        chk("notmo_m_read_held", 32'(m_read), 32'(1));
        chk("notmo_error", 32'(error), 32'(0));
        chk("notmo_rsp_valid", 32'(rsp_valid), 32'(0));
`endif
        // Queue two writes behind the stalled read, then reset mid-cycle.
        offer(2'b00, 8'h50, 32'h5);
        step();
        offer(2'b00, 8'h51, 32'h6);
        step();
        cmd_valid = 1'b0;
        chk("pre_rst_m_read", 32'(m_read), 32'(1));
        #2;
        reset = 1'b1;
        #1;
        chk("mid_rst_m_read", 32'(m_read), 32'(0));
        chk("mid_rst_m_write", 32'(m_write), 32'(0));
        chk("mid_rst_m_address", 32'(m_address), 32'(0));
        chk("mid_rst_error", 32'(error), 32'(0));
        chk("mid_rst_rsp_valid", 32'(rsp_valid), 32'(0));
        chk("mid_rst_busy", 32'(busy), 32'(0));
        chk("mid_rst_cmd_ready", 32'(cmd_ready), 32'(1));
        #10;
        reset = 1'b0;
        m_waitrequest = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("post_rst_discarded", 32'(m_write || m_read), 32'(0));
        end
        chk("post_rst_idle", 32'(busy), 32'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
